// File: rtl/board_state_ctrl.sv
// board_state_ctrl: owns the 8x8 game state and drives the packed board_data
// bus for the display stage. Runs on the pixel clock so board_data is
// already in the display domain and register-stable.
// Optional build macro: BOARD_VBLANK_COMMIT_EN -- when defined, board_data
// only loads during vertical blank (ven = 0) so no frame shows a half move.
module board_state_ctrl #(
  parameter int CURSOR_INIT_ROW = 7,
  parameter int CURSOR_INIT_COL = 4,
  parameter int FIRST_TURN      = 0,
  parameter int CURSOR_WRAP     = 0
) (
  input  logic         pclk,
  input  logic         rstn,
  input  logic         ven,
  input  logic         btn_up,
  input  logic         btn_down,
  input  logic         btn_left,
  input  logic         btn_right,
  input  logic         btn_ok,
  input  logic         btn_cancel,
  output logic [767:0] board_data,
  output logic         turn,
  output logic         game_over,
  output logic         winner,
  output logic         move_done
);

  // piece = {occupied, color, kind[2:0]}
  typedef logic [63:0][4:0]  pieces_t;
  typedef logic [63:0][11:0] board_t;
  typedef enum logic [1:0] {S_IDLE, S_SEL, S_OVER} state_t;

  localparam logic [2:0] K_WANG = 3'd1;
  localparam logic [2:0] K_HOU  = 3'd2;
  localparam logic [2:0] K_SHI  = 3'd3;
  localparam logic [2:0] K_MA   = 3'd4;
  localparam logic [2:0] K_CHE  = 3'd5;
  localparam logic [2:0] K_ZU   = 3'd6;

  function automatic logic [4:0] init_piece(int s);
    int         r;
    int         c;
    logic [2:0] back;
    logic [4:0] p;
    r = s / 8;
    c = s % 8;
    case (c)
      0, 7:    back = K_CHE;
      1, 6:    back = K_MA;
      2, 5:    back = K_SHI;
      3:       back = K_HOU;
      default: back = K_WANG;
    endcase
    case (r)
      0:       p = {1'b1, 1'b1, back};
      1:       p = {1'b1, 1'b1, K_ZU};
      6:       p = {1'b1, 1'b0, K_ZU};
      7:       p = {1'b1, 1'b0, back};
      default: p = 5'd0;
    endcase
    return p;
  endfunction

  function automatic pieces_t init_pieces();
    pieces_t p;
    for (int s = 0; s < 64; s++) p[s] = init_piece(s);
    return p;
  endfunction

  function automatic board_t init_board();
    board_t b;
    for (int s = 0; s < 64; s++)
      b[s] = {(s == CURSOR_INIT_ROW * 8 + CURSOR_INIT_COL), 1'b0, 5'd0, init_piece(s)};
    return b;
  endfunction

  // Edge handling: wrap mod 8 or saturate.
  function automatic logic [2:0] step_dec(logic [2:0] v);
    if (CURSOR_WRAP != 0) return v - 3'd1;
    return (v == 3'd0) ? v : v - 3'd1;
  endfunction

  function automatic logic [2:0] step_inc(logic [2:0] v);
    if (CURSOR_WRAP != 0) return v + 3'd1;
    return (v == 3'd7) ? v : v + 3'd1;
  endfunction

  localparam pieces_t INIT_PIECES = init_pieces();
  localparam board_t  INIT_BOARD  = init_board();

  state_t     state;
  pieces_t    piece;
  logic [2:0] cur_row, cur_col, sel_row, sel_col;
  board_t     board_next, board_q;

  logic [5:0] cur_sq, sel_sq;
  logic [4:0] cur_piece;
  logic       own_sq, capt_wang, sel_on;
  logic       act_cancel, act_ok, act_up, act_down, act_left, act_right;

  assign cur_sq    = {cur_row, cur_col};
  assign sel_sq    = {sel_row, sel_col};
  assign cur_piece = piece[cur_sq];
  assign own_sq    = cur_piece[4] && (cur_piece[3] == turn);
  assign capt_wang = cur_piece[4] && (cur_piece[2:0] == K_WANG);
  assign sel_on    = (state == S_SEL);

  // One action per cycle: cancel > ok > up > down > left > right.
  assign act_cancel = btn_cancel;
  assign act_ok     = btn_ok    && !btn_cancel;
  assign act_up     = btn_up    && !btn_cancel && !btn_ok;
  assign act_down   = btn_down  && !btn_cancel && !btn_ok && !btn_up;
  assign act_left   = btn_left  && !btn_cancel && !btn_ok && !btn_up && !btn_down;
  assign act_right  = btn_right && !btn_cancel && !btn_ok && !btn_up && !btn_down && !btn_left;

  // Per-square display word built from the registered state.
  for (genvar s = 0; s < 64; s++) begin : g_sq
    assign board_next[s] = {cur_sq == 6'(s), sel_on && (sel_sq == 6'(s)), 5'd0, piece[s]};
  end

  // Game FSM: selection, commit/capture, turn, cursor and game-over tracking.
  always_ff @(posedge pclk or negedge rstn) begin
    if (!rstn) begin
      state     <= S_IDLE;
      piece     <= INIT_PIECES;
      cur_row   <= 3'(CURSOR_INIT_ROW);
      cur_col   <= 3'(CURSOR_INIT_COL);
      sel_row   <= 3'd0;
      sel_col   <= 3'd0;
      turn      <= 1'(FIRST_TURN);
      game_over <= 1'b0;
      winner    <= 1'b0;
      move_done <= 1'b0;
    end else begin
      move_done <= 1'b0;
      if (state != S_OVER) begin
        if (act_up)    cur_row <= step_dec(cur_row);
        if (act_down)  cur_row <= step_inc(cur_row);
        if (act_left)  cur_col <= step_dec(cur_col);
        if (act_right) cur_col <= step_inc(cur_col);
      end
      case (state)
        S_IDLE: begin
          if (act_ok && own_sq) begin
            sel_row <= cur_row;
            sel_col <= cur_col;
            state   <= S_SEL;
          end
        end
        S_SEL: begin
          if (act_cancel) begin
            state <= S_IDLE;
          end else if (act_ok) begin
            if (cur_sq == sel_sq) begin
              state <= S_IDLE;
            end else if (own_sq) begin
              sel_row <= cur_row;
              sel_col <= cur_col;
            end else begin
              // Commit: no legality checks, any empty or enemy square is taken.
              piece[cur_sq] <= piece[sel_sq];
              piece[sel_sq] <= 5'd0;
              turn          <= !turn;
              move_done     <= 1'b1;
              if (capt_wang) begin
                game_over <= 1'b1;
                winner    <= turn;
                state     <= S_OVER;
              end else begin
                state <= S_IDLE;
              end
            end
          end
        end
        default: ;  // S_OVER: frozen until reset
      endcase
    end
  end

`ifdef BOARD_VBLANK_COMMIT_EN
  // Shadow copy only follows the working state during vertical blank.
  always_ff @(posedge pclk or negedge rstn) begin
    if (!rstn)     board_q <= INIT_BOARD;
    else if (!ven) board_q <= board_next;
  end
`else
  logic unused_ven;
  assign unused_ven = ven;

  // Display copy follows the working state every cycle, one cycle behind.
  always_ff @(posedge pclk or negedge rstn) begin
    if (!rstn) board_q <= INIT_BOARD;
    else       board_q <= board_next;
  end
`endif

  assign board_data = board_q;

endmodule

// File: tb/tb_board_state_ctrl.sv
// tb_board_state_ctrl: scoreboard bench for board_state_ctrl. A behavioural
// game model predicts every cycle's outputs; predictions are queued at the
// clock edge and compared against the DUT half a cycle later. Scripted
// checks cover reset layout, cursor edges, moves, selection and capture.
module tb_board_state_ctrl;

  logic         pclk = 1'b0;
  logic         rstn = 1'b0;
  logic         ven = 1'b0;
  logic         btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic         btn_ok = 1'b0, btn_cancel = 1'b0;
  logic [767:0] board_data, bd_wrap;
  logic         turn, game_over, winner, move_done;
  logic         turn_w, go_w, win_w, md_w;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 pclk = ~pclk;

  board_state_ctrl dut (
    .pclk(pclk), .rstn(rstn), .ven(ven),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .btn_ok(btn_ok), .btn_cancel(btn_cancel),
    .board_data(board_data), .turn(turn), .game_over(game_over),
    .winner(winner), .move_done(move_done)
  );

  // Wrapping variant; only its cursor behaviour is checked.
  board_state_ctrl #(.CURSOR_WRAP(1)) dut_wrap (
    .pclk(pclk), .rstn(rstn), .ven(ven),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .btn_ok(btn_ok), .btn_cancel(btn_cancel),
    .board_data(bd_wrap), .turn(turn_w), .game_over(go_w),
    .winner(win_w), .move_done(md_w)
  );

  task automatic chk(input string tag, input logic [767:0] got, input logic [767:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] sq(input logic [767:0] b, input int s);
    return b[12*s +: 12];
  endfunction

  // ---------------- reference model (wrap = 0) ----------------
  typedef struct {
    logic [767:0] b;
    logic t, go, w, md;
  } exp_t;
  exp_t q[$];

  logic [4:0] m_piece [64];
  int   m_cr, m_cc, m_ss, m_state;  // state: 0 idle, 1 selected, 2 over
  logic m_turn, m_go, m_win, m_md;
  logic [767:0] m_shadow;

  function automatic logic [767:0] m_pack();
    logic [767:0] r;
    logic [11:0]  w;
    r = '0;
    for (int s = 0; s < 64; s++) begin
      w = {7'd0, m_piece[s]};
      if (s == m_cr * 8 + m_cc) w[11] = 1'b1;
      if (m_state == 1 && s == m_ss) w[10] = 1'b1;
      r[12*s +: 12] = w;
    end
    return r;
  endfunction

  task automatic m_reset();
    int back [8] = '{5, 4, 3, 2, 1, 3, 4, 5};
    for (int s = 0; s < 64; s++) m_piece[s] = 5'd0;
    for (int c = 0; c < 8; c++) begin
      m_piece[c]      = 5'h18 | 5'(back[c]);
      m_piece[8 + c]  = 5'h1E;
      m_piece[48 + c] = 5'h16;
      m_piece[56 + c] = 5'h10 | 5'(back[c]);
    end
    m_cr = 7; m_cc = 4; m_ss = 0; m_state = 0;
    m_turn = 0; m_go = 0; m_win = 0; m_md = 0;
    m_shadow = m_pack();
  endtask

  task automatic m_step();
    int s;
    logic [4:0] p;
    logic own;
    m_md = 0;
    if (m_state == 2) return;
    s = m_cr * 8 + m_cc;
    p = m_piece[s];
    own = p[4] && (p[3] == m_turn);
    if (btn_cancel) begin
      if (m_state == 1) m_state = 0;
    end else if (btn_ok) begin
      if (m_state == 0) begin
        if (own) begin m_ss = s; m_state = 1; end
      end else if (s == m_ss) m_state = 0;
      else if (own) m_ss = s;
      else begin
        m_piece[s] = m_piece[m_ss];
        m_piece[m_ss] = 5'd0;
        m_md = 1;
        if (p[4] && p[2:0] == 3'd1) begin m_go = 1; m_win = m_turn; m_state = 2; end
        else m_state = 0;
        m_turn = !m_turn;
      end
    end
    else if (btn_up)    begin if (m_cr > 0) m_cr--; end
    else if (btn_down)  begin if (m_cr < 7) m_cr++; end
    else if (btn_left)  begin if (m_cc > 0) m_cc--; end
    else if (btn_right) begin if (m_cc < 7) m_cc++; end
  endtask

  // Predict at each edge; board_data lags the working state by one edge.
  initial begin
    exp_t e;
    logic [767:0] b;
    m_reset();
    forever begin
      @(posedge pclk or negedge rstn);
      if (!rstn) begin
        m_reset();
        q.delete();
      end else begin
        b = m_pack();
`ifdef BOARD_VBLANK_COMMIT_EN
        if (!ven) m_shadow = b;
        b = m_shadow;
`endif
        m_step();
        e.b = b; e.t = m_turn; e.go = m_go; e.w = m_win; e.md = m_md;
        q.push_back(e);
      end
    end
  end

  // Compare queued predictions away from the active edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge pclk);
      if (rstn && q.size() > 0) begin
        e = q.pop_front();
        chk("sb_board", board_data, e.b);
        chk("sb_flags", {game_over, winner, turn, move_done}, {e.go, e.w, e.t, e.md});
      end
    end
  end

  // ---------------- stimulus ----------------
  localparam logic [5:0] B_CAN = 6'b100000, B_OK = 6'b010000, B_UP = 6'b001000;
  localparam logic [5:0] B_DN = 6'b000100, B_LT = 6'b000010, B_RT = 6'b000001;

  task automatic pulse(input logic [5:0] b);
    @(negedge pclk);
    {btn_cancel, btn_ok, btn_up, btn_down, btn_left, btn_right} = b;
    @(posedge pclk);
    #1;
    {btn_cancel, btn_ok, btn_up, btn_down, btn_left, btn_right} = 6'b0;
  endtask

  task automatic pulses(input logic [5:0] b, input int n);
    for (int i = 0; i < n; i++) pulse(b);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge pclk);
  endtask

  logic [767:0] snap, sel_mask;

  initial begin
    sel_mask = '0;
    for (int s = 0; s < 64; s++) sel_mask[12*s + 10] = 1'b1;

    // Reset layout
    wait_cyc(2);
    chk("rst_sq60", 768'(sq(board_data, 60)), 768'h811);
    chk("rst_sq4",  768'(sq(board_data, 4)),  768'h019);
    chk("rst_sq27", 768'(sq(board_data, 27)), 768'h000);
    chk("rst_flags", {game_over, winner, turn, move_done}, 4'b0);
    rstn = 1'b1;

    // Cursor edge: saturate vs wrap
    pulses(B_LT, 5);
    wait_cyc(2);
    chk("sat_sq56",  768'(sq(board_data, 56)), 768'h815);
    chk("sat_sq60",  768'(sq(board_data, 60)), 768'h011);
    chk("wrap_sq63", 768'(sq(bd_wrap, 63)),    768'h815);

    // White zu 48 -> 32
    pulse(B_UP);
    pulse(B_OK);
    pulses(B_UP, 2);
    pulse(B_OK);
    chk("md_hi", 768'(move_done), 768'h1);
    chk("turn_black", 768'(turn), 768'h1);
    @(posedge pclk); #1;
    chk("md_lo", 768'(move_done), 768'h0);
    wait_cyc(2);
    chk("mv_sq48", 768'(sq(board_data, 48)), 768'h000);
    chk("mv_sq32", 768'(sq(board_data, 32) & 12'h7FF), 768'h016);

    // Black to move: ok on a white piece is ignored
    snap = board_data;
    pulse(B_OK);
    wait_cyc(2);
    chk("ign_board", board_data, snap);
    chk("ign_nosel", board_data & sel_mask, 768'h0);

    // Select own piece, then cancel
    pulses(B_UP, 3);
    pulse(B_OK);
    wait_cyc(2);
    chk("sel_sq8", 768'(sq(board_data, 8)), 768'hC1E);
    pulse(B_CAN);
    wait_cyc(2);
    chk("can_sq8", 768'(sq(board_data, 8)), 768'h81E);

    // ok + up on the source: deselect only, cursor stays
    pulse(B_OK);
    pulse(B_OK | B_UP);
    wait_cyc(2);
    chk("okup_sq8", 768'(sq(board_data, 8)), 768'h81E);
    chk("okup_nosel", board_data & sel_mask, 768'h0);

    // Black zu 8 -> 16 committed during active video
    snap = board_data;
    @(negedge pclk); ven = 1'b1;
    pulse(B_OK);
    pulse(B_DN);
    pulse(B_OK);
    chk("vb_turn", 768'(turn), 768'h0);
    wait_cyc(3);
`ifdef BOARD_VBLANK_COMMIT_EN
    chk("vb_hold", board_data, snap);
`else
    chk("vb_live", 768'(sq(board_data, 16)), 768'h81E);
`endif
    ven = 1'b0;
    wait_cyc(2);
    chk("vb_sq16", 768'(sq(board_data, 16)), 768'h81E);
    chk("vb_sq8",  768'(sq(board_data, 8)),  768'h000);

    // White zu 32 captures the black wang at square 4
    pulses(B_DN, 2);
    pulse(B_OK);
    pulses(B_UP, 4);
    pulses(B_RT, 4);
    pulse(B_OK);
    chk("cap_over", {game_over, winner}, 2'b10);
    wait_cyc(2);
    chk("cap_sq4",  768'(sq(board_data, 4)),  768'h816);
    chk("cap_sq32", 768'(sq(board_data, 32)), 768'h000);

    // Frozen after game over
    snap = board_data;
    pulse(B_LT); pulse(B_OK); pulse(B_DN); pulse(B_CAN); pulse(B_RT);
    wait_cyc(2);
    chk("over_frozen", board_data, snap);
    chk("over_flags", {game_over, winner}, 2'b10);

    // Mid-game reset restores the layout immediately
    @(negedge pclk); rstn = 1'b0;
    #1;
    chk("rst2_sq60", 768'(sq(board_data, 60)), 768'h811);
    chk("rst2_sq4",  768'(sq(board_data, 4)),  768'h019);
    chk("rst2_flags", {game_over, winner, turn, move_done}, 4'b0);
    wait_cyc(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/board_state_ctrl.md
Name: board_state_ctrl

Overview:
- Owns the 8x8 game state and drives the packed `board_data` bus consumed by the display stage (DDP), which is directly downstream.
- Takes single-cycle button pulses. Moves the cursor, selects a piece, and commits moves or captures. Tracks whose turn it is and detects game over when a wang is captured.
- Clocked on the pixel clock so `board_data` is register-stable and already in the display clock domain.

Parameters:
- CURSOR_INIT_ROW, 7, cursor row after reset (0..7).
- CURSOR_INIT_COL, 4, cursor column after reset (0..7).
- FIRST_TURN, 0, side to move after reset (0 = white, 1 = black).
- CURSOR_WRAP, 0, 1 = cursor wraps at board edges; 0 = cursor saturates at edges.

Ports:
- pclk  in  1  clock.
- rstn  in  1  asynchronous reset, active-low.
- ven  in  1  vertical active-video flag from the timing generator.
- btn_up, btn_down, btn_left, btn_right  in  1 each  debounced single-cycle pulses.
- btn_ok  in  1  select / commit pulse.
- btn_cancel  in  1  deselect pulse.
- board_data  out  768  square s = row*8+col occupies [12*s +: 12].
- turn  out  1  side to move.
- game_over  out  1  high once a wang has been captured.
- winner  out  1  side that made the capture; valid only while game_over is high.
- move_done  out  1  one-cycle pulse on each committed move.

Behaviour:
- Square word fields:
  - bit11 = cursor.
  - bit10 = selected.
  - bits9:5 = 0.
  - bit4 = occupied.
  - bits3:0 = type {color, kind[2:0]}. color 0 = white, 1 = black.
  - kind codes: 001 wang, 010 hou, 011 shi, 100 ma, 101 che, 110 zu.
  - An empty square has bits4:0 = 0.
- Reset (asynchronous, all outputs):
  - Row 0: black che, ma, shi, hou, wang, shi, ma, che in cols 0..7.
  - Row 1: black zu in all columns.
  - Row 6: white zu in all columns.
  - Row 7: white back rank, same column order as row 0.
  - All other squares empty.
  - Cursor at (CURSOR_INIT_ROW, CURSOR_INIT_COL). No square selected.
  - turn = FIRST_TURN, game_over = 0, winner = 0, move_done = 0. FSM in S_IDLE.
- Internal state: piece array 64x5, cursor row/col (3 bits each), select row/col, FSM.
- `board_data` is rebuilt every cycle from registered state and is itself registered, so it always reflects the previous cycle's state.
- Action arbitration: at most one action per cycle. Priority: cancel > ok > up > down > left > right.
- Cursor moves:
  - Up = row-1, down = row+1, left = col-1, right = col+1.
  - At an edge the cursor holds when CURSOR_WRAP=0 and wraps mod 8 when CURSOR_WRAP=1.
  - Cursor moves are allowed in S_IDLE and S_SEL.
- FSM states: S_IDLE, S_SEL, S_OVER.
- S_IDLE:
  - ok on a square occupied by the side to move → latch the cursor square as the source; go to S_SEL.
  - ok on any other square → ignored.
  - cancel → ignored.
- S_SEL:
  - cancel → S_IDLE, selection cleared.
  - ok on the source square → S_IDLE, selection cleared.
  - ok on another own-colour piece → re-select it as the source; stay in S_SEL.
  - ok on an empty or opponent square → commit the move in the same clock edge:
    - destination ← source piece; source ← empty; selection cleared.
    - turn toggles; move_done = 1 for 1 cycle.
    - If the captured piece is a wang: game_over = 1, winner = mover, next state S_OVER.
    - Otherwise next state S_IDLE.
  - No per-piece legality checks.
- S_OVER:
  - All buttons ignored; board frozen; cursor frozen.
  - Left only by reset.
- Latency: a button pulse sampled at edge t changes internal state at t; `board_data` reflects the change at edge t+1.
- Reset asserted mid-operation aborts any selection and restores the initial layout immediately.

Optional Feature:
- Macro `BOARD_VBLANK_COMMIT_EN`.
- Defined:
  - `board_data` is a shadow register loaded from the working state only on cycles where ven = 0 (vertical blank).
  - During active video it holds, so no frame shows a half-applied move.
  - turn, game_over, winner and move_done remain immediate.
- Undefined: `board_data` loads every cycle and ven is unused.
- Reset initialises the shadow register to the initial layout in both builds.

Test Plan:
- Reset with defaults → square 60 word = 0x811 (cursor, white wang). Square 4 word = 0x019. Square 27 word = 0x000. turn = 0.
- Cursor at (7,4): btn_left ×5 with CURSOR_WRAP=0 → cursor at (7,0). Same sequence with CURSOR_WRAP=1 → cursor at (7,7).
- Cursor to (6,0), ok; btn_up ×2, ok → square 48 = 0x000, square 32 = 0x016, turn = 1, move_done high exactly 1 cycle.
- In S_IDLE with turn = 0, ok on a black piece → state unchanged, no bit10 set anywhere. Then select own piece and cancel → bit10 cleared, S_IDLE.
- btn_ok and btn_up in the same cycle while in S_SEL on the source square → deselect only, cursor unchanged.
- Scripted capture of the black wang at square 4 → game_over = 1, winner = 0. Subsequent button pulses leave `board_data` unchanged. With `BOARD_VBLANK_COMMIT_EN` and ven = 1, `board_data` holds until ven = 0.
